// File: rtl/hood_pkg.sv
// Shared definitions for the cooker-hood controller: state codes, button commands, level width.
// Latency: none (types and constant functions only). Backpressure: n/a.
// Sibling blocks import this package.
package hood_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_STANDBY = 3'd1,
    ST_RUN     = 3'd2,
    ST_STORM   = 3'd3,
    ST_CLEAN   = 3'd4
  } hood_state_t;

  // One winning button per clk after priority resolution.
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_STOP,
    CMD_STORM,
    CMD_CLEAN,
    CMD_UP,
    CMD_DOWN
  } hood_cmd_t;

  // Fan level must hold 0 (off), 1..num_levels and the storm level num_levels+1.
  function automatic int lvl_width(input int num_levels);
    return $clog2(num_levels + 2);
  endfunction

endpackage

// File: rtl/hood_sec_timer.sv
// Loadable 16-bit seconds down-counter; expire marks the tick that takes the count from 1 to 0.
// Latency: load/clear/decrement registered; expire is combinational in the clk of that tick.
// Backpressure: none; load beats clear beats tick, and the count never wraps below 0.
module hood_sec_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        clear,
  input  logic        tick,
  output logic [15:0] count,
  output logic        expire
);

  assign expire = tick && (count == 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != 16'd0)) begin
      count <= count - 16'd1;
    end
  end

endmodule

// File: rtl/hood_mode_ctrl.sv
// Cooker-hood mode controller (OFF/STANDBY/RUN/STORM/CLEAN) with fan level, timed modes and clean reminder.
// Latency: every transition registered, visible one clk after its cause. Backpressure: none, losing pulses are dropped.
// Idle auto-off request is built only when HOOD_AUTO_OFF_EN is defined; otherwise auto_off is tied low.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int NUM_LEVELS = 3,
  parameter int STORM_SEC  = 60,
  parameter int CLEAN_SEC  = 180,
  parameter int REMIND_SEC = 36000,
  parameter int IDLE_SEC   = 300,
  localparam int LW        = lvl_width(NUM_LEVELS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_1hz,
  input  logic          power_on,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_stop,
  input  logic          btn_storm,
  input  logic          btn_clean,
  output logic [2:0]    state,
  output logic [LW-1:0] fan_level,
  output logic [15:0]   countdown,
  output logic [23:0]   work_sec,
  output logic          remind,
  output logic          auto_off
);

  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_MAX   = LW'(NUM_LEVELS);
  localparam logic [LW-1:0] LVL_STORM = LW'(NUM_LEVELS + 1);

  hood_state_t   state_q, state_nxt;
  logic [LW-1:0] lvl_q, lvl_nxt;
  logic          storm_used_q;
  hood_cmd_t     cmd;
  logic          tmr_load, tmr_clear, tmr_expire;
  logic [15:0]   tmr_load_val;
  logic          clean_done;
  logic [23:0]   work_nxt;

  always_comb begin
    cmd = CMD_NONE;
    if (btn_stop)       cmd = CMD_STOP;
    else if (btn_storm) cmd = CMD_STORM;
    else if (btn_clean) cmd = CMD_CLEAN;
    else if (btn_up)    cmd = CMD_UP;
    else if (btn_down)  cmd = CMD_DOWN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_OFF;
      lvl_q        <= '0;
      storm_used_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      lvl_q   <= lvl_nxt;
      if (!power_on)               storm_used_q <= 1'b0;
      else if (state_nxt == ST_STORM) storm_used_q <= 1'b1;
    end
  end

  // An ignored button in STORM/CLEAN lets a coincident expiry still take effect.
  always_comb begin
    state_nxt = state_q;
    lvl_nxt   = lvl_q;
    if (!power_on) begin
      state_nxt = ST_OFF;
      lvl_nxt   = '0;
    end else begin
      case (state_q)
        ST_OFF: state_nxt = ST_STANDBY;
        ST_STANDBY: begin
          case (cmd)
            CMD_STORM: if (!storm_used_q) begin
              state_nxt = ST_STORM;
              lvl_nxt   = LVL_STORM;
            end
            CMD_CLEAN: state_nxt = ST_CLEAN;
            CMD_UP: begin
              state_nxt = ST_RUN;
              lvl_nxt   = LVL_ONE;
            end
            default: ;
          endcase
        end
        ST_RUN: begin
          case (cmd)
            CMD_STOP: begin
              state_nxt = ST_STANDBY;
              lvl_nxt   = '0;
            end
            CMD_STORM: if (!storm_used_q) begin
              state_nxt = ST_STORM;
              lvl_nxt   = LVL_STORM;
            end
            CMD_UP: if (lvl_q < LVL_MAX) lvl_nxt = lvl_q + LVL_ONE;
            CMD_DOWN: begin
              if (lvl_q <= LVL_ONE) begin
                state_nxt = ST_STANDBY;
                lvl_nxt   = '0;
              end else begin
                lvl_nxt = lvl_q - LVL_ONE;
              end
            end
            default: ;
          endcase
        end
        ST_STORM: begin
          if (cmd == CMD_STOP) begin
            state_nxt = ST_STANDBY;
            lvl_nxt   = '0;
          end else if (tmr_expire) begin
            state_nxt = ST_RUN;
            lvl_nxt   = LVL_MAX;
          end
        end
        ST_CLEAN: begin
          if ((cmd == CMD_STOP) || tmr_expire) begin
            state_nxt = ST_STANDBY;
            lvl_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_OFF;
          lvl_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_clear    = 1'b0;
    if ((state_nxt != state_q) && (state_nxt == ST_STORM)) begin
      tmr_load     = 1'b1;
      tmr_load_val = 16'(STORM_SEC);
    end else if ((state_nxt != state_q) && (state_nxt == ST_CLEAN)) begin
      tmr_load     = 1'b1;
      tmr_load_val = 16'(CLEAN_SEC);
    end
    if ((state_nxt != ST_STORM) && (state_nxt != ST_CLEAN)) tmr_clear = 1'b1;
    clean_done = (state_q == ST_CLEAN) && (state_nxt == ST_STANDBY) && (cmd != CMD_STOP);
    state      = state_q;
    fan_level  = lvl_q;
  end

  hood_sec_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .clear    (tmr_clear),
    .tick     (tick_1hz),
    .count    (countdown),
    .expire   (tmr_expire)
  );

  always_comb begin
    work_nxt = work_sec;
    if (tick_1hz && (lvl_q != '0) && (work_sec != '1)) work_nxt = work_sec + 24'd1;
  end

  // Remind rises in the same clk work_sec reaches the threshold and survives power-off.
  always_ff @(posedge clk) begin
    if (reset) begin
      work_sec <= '0;
      remind   <= 1'b0;
    end else if (clean_done) begin
      work_sec <= '0;
      remind   <= 1'b0;
    end else begin
      work_sec <= work_nxt;
      if (work_nxt >= 24'(REMIND_SEC)) remind <= 1'b1;
    end
  end

`ifdef HOOD_AUTO_OFF_EN
  localparam int IW = (IDLE_SEC > 1) ? $clog2(IDLE_SEC + 1) : 1;

  logic [IW-1:0] idle_cnt;
  logic          idle_hold;

  assign idle_hold = (state_q == ST_STANDBY) && (state_nxt == ST_STANDBY) &&
                     !(btn_up || btn_down || btn_stop || btn_storm || btn_clean);

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
      auto_off <= 1'b0;
    end else begin
      auto_off <= 1'b0;
      if (!idle_hold) begin
        idle_cnt <= '0;
      end else if (tick_1hz) begin
        if (idle_cnt == IW'(IDLE_SEC - 1)) begin
          idle_cnt <= '0;
          auto_off <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end
    end
  end
`else
  assign auto_off = 1'b0;
`endif

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Self-checking bench for hood_mode_ctrl: directed scenarios then random stimulus against a behavioural model.
// Every output is compared one step after each clock edge; HOOD_AUTO_OFF_EN selects the idle-request expectation.
module tb_hood_mode_ctrl;
  import hood_pkg::*;

  localparam int N      = 3;
  localparam int STORM  = 60;
  localparam int CLEAN  = 180;
  localparam int REMIND = 36000;
  localparam int IDLE   = 300;
  localparam int LW     = lvl_width(N);
  localparam int WMAX   = 24'hFFFFFF;

  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_STOP  = 5'b10000;
  localparam logic [4:0] B_STORM = 5'b01000;
  localparam logic [4:0] B_CLEAN = 5'b00100;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00001;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick_1hz = 1'b0;
  logic          power_on = 1'b0;
  logic          btn_up = 1'b0, btn_down = 1'b0, btn_stop = 1'b0, btn_storm = 1'b0, btn_clean = 1'b0;
  logic [2:0]    state;
  logic [LW-1:0] fan_level;
  logic [15:0]   countdown;
  logic [23:0]   work_sec;
  logic          remind;
  logic          auto_off;

  int checks = 0;
  int errors = 0;
  int ao_pulses = 0;

  // Model: mode 0..4 = off/standby/run/storm/clean
  int m_mode, m_lvl, m_cd, m_work, m_rem, m_su, m_idle, m_ao;

  hood_mode_ctrl #(
    .NUM_LEVELS (N),
    .STORM_SEC  (STORM),
    .CLEAN_SEC  (CLEAN),
    .REMIND_SEC (REMIND),
    .IDLE_SEC   (IDLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_1hz  (tick_1hz),
    .power_on  (power_on),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_stop  (btn_stop),
    .btn_storm (btn_storm),
    .btn_clean (btn_clean),
    .state     (state),
    .fan_level (fan_level),
    .countdown (countdown),
    .work_sec  (work_sec),
    .remind    (remind),
    .auto_off  (auto_off)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit pw, input bit tk, input logic [4:0] b);
    bit moved;
    bit done;
    int prev;
    moved = 0;
    done  = 0;
    if (r) begin
      m_mode = 0; m_lvl = 0; m_cd = 0; m_work = 0; m_rem = 0; m_su = 0; m_idle = 0; m_ao = 0;
      return;
    end
    prev = m_mode;
    m_ao = 0;
    if (tk && m_lvl > 0 && m_work < WMAX) m_work++;
    if (!pw) begin
      m_mode = 0; m_lvl = 0; m_cd = 0; m_su = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else begin
      if (b[4]) begin
        if (m_mode >= 2) begin m_mode = 1; m_lvl = 0; m_cd = 0; moved = 1; end
      end else if (b[3]) begin
        if ((m_mode == 1 || m_mode == 2) && m_su == 0) begin
          m_mode = 3; m_lvl = N + 1; m_cd = STORM; m_su = 1; moved = 1;
        end
      end else if (b[2]) begin
        if (m_mode == 1) begin m_mode = 4; m_lvl = 0; m_cd = CLEAN; moved = 1; end
      end else if (b[1]) begin
        if (m_mode == 1) begin m_mode = 2; m_lvl = 1; end
        else if (m_mode == 2 && m_lvl < N) m_lvl++;
      end else if (b[0]) begin
        if (m_mode == 2) begin
          if (m_lvl == 1) begin m_mode = 1; m_lvl = 0; end
          else m_lvl--;
        end
      end
      if (!moved && (m_mode == 3 || m_mode == 4) && tk && m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          if (m_mode == 3) begin m_mode = 2; m_lvl = N; end
          else begin m_mode = 1; m_work = 0; m_rem = 0; done = 1; end
        end
      end
    end
    if (!done && m_work >= REMIND) m_rem = 1;
`ifdef HOOD_AUTO_OFF_EN
    if (prev == 1 && m_mode == 1 && b == 5'b0) begin
      if (tk) begin
        m_idle++;
        if (m_idle == IDLE) begin m_ao = 1; m_idle = 0; end
      end
    end else begin
      m_idle = 0;
    end
`else
    if (prev < 0) m_idle = 0;
`endif
  endtask

  task automatic check_all();
    chk("state", 32'(state), m_mode);
    chk("fan_level", 32'(fan_level), m_lvl);
    chk("countdown", 32'(countdown), m_cd);
    chk("work_sec", 32'(work_sec), m_work);
    chk("remind", 32'(remind), m_rem);
    chk("auto_off", 32'(auto_off), m_ao);
    if (auto_off === 1'b1) ao_pulses++;
  endtask

  task automatic step(input logic [4:0] b, input bit t);
    {btn_stop, btn_storm, btn_clean, btn_up, btn_down} = b;
    tick_1hz = t;
    @(posedge clk);
    model_step(reset, power_on, t, b);
    #1;
    check_all();
    {btn_stop, btn_storm, btn_clean, btn_up, btn_down} = 5'b0;
    tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(B_NONE, 1'b1);
  endtask

  initial begin
    int w0;
    logic [4:0] rb;
    bit rt;

    // Reset state
    reset = 1'b1; power_on = 1'b0;
    step(B_NONE, 1'b0);
    chk("rst_state", 32'(state), 0);
    chk("rst_work", 32'(work_sec), 0);
    reset = 1'b0;

    // Level stepping with saturation and drop to standby
    power_on = 1'b1;
    step(B_NONE, 1'b0);
    chk("standby", 32'(state), 1);
    step(B_UP, 0); chk("up1", 32'(fan_level), 1);
    step(B_UP, 0); chk("up2", 32'(fan_level), 2);
    step(B_UP, 0); chk("up3", 32'(fan_level), 3);
    step(B_UP, 0); chk("up_sat", 32'(fan_level), 3);
    step(B_DOWN, 0); chk("dn2", 32'(fan_level), 2);
    step(B_DOWN, 0); chk("dn1", 32'(fan_level), 1);
    step(B_DOWN, 0); chk("dn_standby", 32'(state), 1);

    // Storm entry, expiry, single-use until power cycle
    step(B_UP, 0); step(B_UP, 0);
    step(B_STORM, 0);
    chk("storm_lvl", 32'(fan_level), 4);
    chk("storm_cd", 32'(countdown), 60);
    ticks(59);
    chk("storm_cd1", 32'(countdown), 1);
    ticks(1);
    chk("storm_exp_state", 32'(state), 2);
    chk("storm_exp_lvl", 32'(fan_level), 3);
    chk("storm_work", 32'(work_sec), 60);
    step(B_STORM, 0); chk("storm_reuse", 32'(state), 2);
    power_on = 1'b0; step(B_NONE, 0); chk("pwr_off", 32'(state), 0);
    power_on = 1'b1; step(B_NONE, 0);
    step(B_STORM, 0); chk("storm_again", 32'(state), 3);
    step(B_STOP, 0); chk("storm_stop", 32'(countdown), 0);

    // Clean abort keeps counters; full clean clears them
    w0 = m_work;
    step(B_CLEAN, 0); chk("clean_cd", 32'(countdown), 180);
    ticks(80); chk("clean_cd100", 32'(countdown), 100);
    step(B_STOP, 0);
    chk("abort_state", 32'(state), 1);
    chk("abort_work", 32'(work_sec), w0);
    step(B_CLEAN, 0); ticks(180);
    chk("clean_done_state", 32'(state), 1);
    chk("clean_done_work", 32'(work_sec), 0);

    // Remind threshold, persistence through off, cleared by clean
    step(B_UP, 0);
    ticks(REMIND - 1); chk("remind_pre", 32'(remind), 0);
    ticks(1);          chk("remind_set", 32'(remind), 1);
    power_on = 1'b0; step(B_NONE, 0); chk("remind_off", 32'(remind), 1);
    power_on = 1'b1; step(B_NONE, 0);
    step(B_CLEAN, 0); ticks(CLEAN);
    chk("remind_clr", 32'(remind), 0);

    // Priority and coincident tick/button cases, reset mid-storm
    step(B_UP, 0); step(B_UP, 0);
    step(B_STOP | B_STORM, 0); chk("stop_over_storm", 32'(state), 1);
    step(B_UP, 0); step(B_STORM, 0);
    ticks(STORM - 1);
    step(B_UP, 1'b1);
    chk("up_tick_state", 32'(state), 2);
    chk("up_tick_lvl", 32'(fan_level), 3);
    power_on = 1'b0; step(B_NONE, 0);
    power_on = 1'b1; step(B_NONE, 0);
    step(B_STORM, 0); ticks(5);
    reset = 1'b1; step(B_UP, 1'b1); reset = 1'b0;
    chk("midrst_state", 32'(state), 0);
    chk("midrst_cd", 32'(countdown), 0);
    chk("midrst_lvl", 32'(fan_level), 0);

    // Idle auto-off: a button at 299 restarts the count
    step(B_NONE, 0);
    ao_pulses = 0;
    ticks(IDLE - 1);
    step(B_DOWN, 0);
    ticks(IDLE);
    step(B_NONE, 0);
`ifdef HOOD_AUTO_OFF_EN
    chk("ao_pulses", ao_pulses, 1);
`else
    chk("ao_pulses", ao_pulses, 0);
`endif

    // Random single-button traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 499) == 0);
      power_on = ($urandom_range(0, 59) != 0);
      rt       = 1'($urandom_range(0, 1));
      rb       = B_NONE;
      if ($urandom_range(0, 2) == 0) rb = 5'b00001 << $urandom_range(0, 4);
      step(rb, rt);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hood_mode_ctrl.md
HOOD_MODE_CTRL -- requirements
Module: hood_mode_ctrl

Interface
REQ-001 Parameter NUM_LEVELS, default 3, number of normal fan levels (>=2); storm level is NUM_LEVELS+1.
REQ-002 Parameter STORM_SEC, default 60, storm duration in seconds.
REQ-003 Parameter CLEAN_SEC, default 180, self-clean duration in seconds.
REQ-004 Parameter REMIND_SEC, default 36000, accumulated fan-on seconds before remind is raised.
REQ-005 Parameter IDLE_SEC, default 300, standby idle time before auto-off request.
REQ-006 clk  in  1  system clock; single clock domain.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 tick_1hz  in  1  one-clk-wide strobe, once per second.
REQ-009 power_on  in  1  level; 0 = appliance off.
REQ-010 btn_up, btn_down, btn_stop, btn_storm, btn_clean  in  1 each  debounced one-clk pulses.
REQ-011 state  out  3  current FSM state code.
REQ-012 fan_level  out  LW = $clog2(NUM_LEVELS+2)  0 = fan off; NUM_LEVELS+1 = storm.
REQ-013 countdown  out  16  seconds remaining in STORM/CLEAN, else 0.
REQ-014 work_sec  out  24  accumulated fan-on seconds, saturating at 2^24-1.
REQ-015 remind  out  1  cleaning reminder.
REQ-016 auto_off  out  1  one-clk pulse requesting power-off.

Function
REQ-017 States: OFF=0, STANDBY=1, RUN=2, STORM=3, CLEAN=4; all transitions registered, effective the clk after the cause.
REQ-018 Any state with power_on=0 -> OFF next clk; fan_level=0, countdown=0, storm_used cleared.
REQ-019 OFF with power_on=1 -> STANDBY.
REQ-020 STANDBY: btn_up -> RUN level 1; btn_storm with storm_used=0 -> STORM; btn_clean -> CLEAN.
REQ-021 RUN: btn_up increments, saturating at NUM_LEVELS; btn_down decrements, level 1 + btn_down -> STANDBY; btn_stop -> STANDBY; btn_storm with storm_used=0 -> STORM.
REQ-022 STORM entry loads countdown=STORM_SEC and sets storm_used; storm_used cleared only by OFF or reset.
REQ-023 STORM: fan_level=NUM_LEVELS+1; btn_stop -> STANDBY; countdown expiry -> RUN level NUM_LEVELS; btn_up/down/storm/clean ignored.
REQ-024 CLEAN entry loads countdown=CLEAN_SEC; fan_level=0; btn_stop aborts -> STANDBY without clearing counters; expiry -> STANDBY, work_sec=0, remind=0.
REQ-025 Countdown decrements on each tick_1hz; value 1 plus tick -> expiry transition that clk; countdown never wraps below 0.
REQ-026 Button priority within one clk: power_on=0 > btn_stop > btn_storm > btn_clean > btn_up > btn_down; lower-priority pulses are dropped.
REQ-027 Button and tick_1hz in the same clk: button transition wins; new state's countdown loads full value, no decrement.
REQ-028 work_sec increments on tick_1hz while fan_level>0; saturates, never wraps.
REQ-029 remind set when work_sec >= REMIND_SEC; held until CLEAN completes or reset; persists through OFF.

Reset
REQ-030 reset: state=OFF, fan_level=0, countdown=0, work_sec=0, remind=0, auto_off=0, storm_used=0, idle counter=0; reset overrides all inputs.

Configuration
REQ-031 Macro HOOD_AUTO_OFF_EN defined: idle counter counts tick_1hz while in STANDBY with no button pulse, cleared on any button or state change; reaching IDLE_SEC pulses auto_off one clk and clears the counter.
REQ-032 HOOD_AUTO_OFF_EN undefined: idle counter not built; auto_off tied 0; port list unchanged.

Structure
REQ-033 Shared package hood_pkg holds state encoding constants (OFF..CLEAN) and the LW width function; sibling blocks import it.
REQ-034 One sub-module hood_sec_timer: 16-bit loadable down-counter with tick enable and one-clk expiry flag, used for STORM/CLEAN countdown.

Verification (defaults; STORM_SEC/CLEAN_SEC/IDLE_SEC may be shrunk to 3/4/5)
REQ-035 power_on=1, btn_up x4 -> RUN, fan_level 1,2,3,3 (saturate); btn_down x3 -> levels 2,1 then STANDBY.
REQ-036 RUN lvl 2, btn_storm -> STORM, fan_level 4, countdown 60; 60 ticks -> RUN fan_level 3; second btn_storm ignored; power cycle then btn_storm accepted.
REQ-037 STANDBY, btn_clean -> CLEAN countdown 180; abort with btn_stop at 100 -> STANDBY, work_sec unchanged; full 180 ticks -> work_sec=0, remind=0.
REQ-038 Preload via 36000 ticks at level 1 -> remind=1 on the tick reaching 36000; power_on=0 -> remind stays 1.
REQ-039 btn_stop and btn_storm same clk in RUN -> STANDBY; btn_up with tick in STORM at countdown 1 -> RUN lvl 3; reset asserted mid-STORM -> all outputs reset values next clk.
REQ-040 HOOD_AUTO_OFF_EN: STANDBY 300 idle ticks -> single auto_off pulse; button at tick 299 restarts count; without macro auto_off never asserts.
